aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Sequencing controller for the AES-256 iterative round datapath. It drives the select of the 128-bit (16×8) state-input 2:1 mux: select 1 takes the new plaintext, select 0 takes round feedback. It also generates the state-register load enable, the round index used for round-key selection, and the last-round flag that bypasses MixColumns. It sits between the host-side plaintext handshake and the round datapath, alongside key expansion.

## Interface
Parameters:
- NR, 14, number of cipher rounds after the initial AddRoundKey; legal range 1..15.
- ROUND_LAT, 1, datapath cycles per round; legal range 1..15.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Reset, asynchronous, active-low. Assertion is asynchronous; deassertion is sampled on clk.
- key_ready  input  1  Expanded key schedule valid.
- in_valid  input  1  Plaintext present on the datapath input.
- in_ready  output  1  Controller accepts plaintext.
- out_valid  output  1  Ciphertext valid in the state register.
- out_ready  input  1  Consumer takes ciphertext.
- mux_sel  output  1  State-input mux select. 1 = plaintext, 0 = feedback.
- state_en  output  1  State register load enable, one cycle per load.
- round_idx  output  4  Round index, 0..NR; indexes round key.
- last_round  output  1  High while round_idx == NR; datapath skips MixColumns.
- busy  output  1  High in ROUND.
- abort  input  1  Present only with AES_CTRL_ABORT_EN.

## Operation
- States: IDLE, ROUND, DONE. One-hot or binary encoding is allowed. A 4-bit wait counter wcnt runs alongside the state.
- IDLE:
  - mux_sel=1, round_idx=0, in_ready=key_ready.
  - When in_valid && in_ready: state_en=1 in that same cycle (loads plaintext XOR key 0), round_idx→1, wcnt→0, go to ROUND.
- ROUND:
  - mux_sel=0, in_ready=0, busy=1.
  - wcnt increments each cycle.
  - When wcnt == ROUND_LAT-1: state_en=1 and wcnt→0.
    - If round_idx < NR: round_idx increments.
    - Else: go to DONE, holding round_idx=NR.
- DONE:
  - out_valid=1, mux_sel=0, state_en=0.
  - When out_ready: go to IDLE and set round_idx→0.
  - No new plaintext is accepted in DONE; at least one IDLE cycle occurs between blocks.
- Key handling:
  - key_ready is sampled only in IDLE.
  - key_ready dropping during ROUND or DONE has no effect.
- Decoding: all outputs are decoded from registered state, round_idx and wcnt. The only combinational paths are in_ready from key_ready and state_en from the IDLE handshake.
- Error case: round_idx never exceeds NR. Reaching NR+1 is an RTL error and must be covered by an assertion.

## Timing
- Reset values:
  - state IDLE, round_idx=0, wcnt=0.
  - mux_sel=1, state_en=0, out_valid=0, busy=0, last_round=0.
  - in_ready=key_ready.
- Accept-cycle reference: accept is cycle 0.
  - state_en pulses at cycle 0 and at cycles k·ROUND_LAT for k=1..NR, giving NR+1 loads in total.
  - out_valid rises at cycle NR·ROUND_LAT+1.
  - With defaults: 15 loads in cycles 0..14, out_valid at cycle 15.
- last_round is high throughout round NR, including its final state_en cycle.
- out_valid holds until out_ready is sampled high. The IDLE transition follows on the next edge.
- Reset mid-operation returns the block to IDLE immediately. No state_en is issued after reset assertion.

## Configuration
- AES_CTRL_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in any state: next state IDLE, round_idx→0, wcnt→0.
  - state_en is forced to 0 in that cycle, and out_valid drops on the next edge.
  - abort has priority over the in_valid handshake and over out_ready.
- AES_CTRL_ABORT_EN undefined: the port is absent and there is no abort behaviour.

## Test plan
- Defaults, key_ready=1, in_valid pulse at cycle 0 → state_en high in cycles 0..14, mux_sel=1 only at cycle 0, last_round high at cycle 14, out_valid at cycle 15.
- ROUND_LAT=3 → state_en at cycles 0,3,6,…,42; out_valid at cycle 43; round_idx steps every 3 cycles.
- key_ready=0 with in_valid=1 for 5 cycles, then key_ready=1 → in_ready=0 and no state_en for 5 cycles; accept occurs on the 6th cycle.
- Hold out_ready=0 for 10 cycles after out_valid → out_valid and round_idx=14 held with no state_en; a new in_valid is not accepted until one cycle after out_ready.
- Assert rst at round 7 → outputs take reset values immediately; the next block completes normally in 15 cycles.
- With AES_CTRL_ABORT_EN, abort at round 5 → no state_en that cycle, IDLE with round_idx=0 next cycle; abort together with in_valid in IDLE → no accept.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Sequencing controller for an iterative AES-256 round datapath. It steers the
// state-input mux (plaintext vs. round feedback), pulses the state register
// load enable once per completed round, and provides the round index used to
// select the round key plus a last-round flag that bypasses MixColumns.
//
// Parameters
//   NR         number of cipher rounds after the initial AddRoundKey (1..15)
//   ROUND_LAT  datapath cycles per round (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   key_ready   expanded key schedule valid (only looked at while idle)
//   in_valid    plaintext present on the datapath input
//   in_ready    controller accepts plaintext
//   out_valid   ciphertext valid in the state register
//   out_ready   consumer takes ciphertext
//   mux_sel     state-input mux select, 1 = plaintext, 0 = feedback
//   state_en    state register load enable, one cycle per load
//   round_idx   round index 0..NR, indexes the round key
//   last_round  high while round_idx == NR
//   busy        high while rounds are being computed
//   abort       only with AES_CTRL_ABORT_EN: return to idle at once
//
// Build option
//   AES_CTRL_ABORT_EN  adds the abort input and its behaviour.
module aes_round_ctrl #(
  parameter int NR        = 14,
  parameter int ROUND_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ready,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       mux_sel,
  output logic       state_en,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic       busy
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam logic [3:0] NrL    = 4'(NR);
  localparam logic [3:0] LatM1L = 4'(ROUND_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] wcnt_q,  wcnt_d;
  logic       loadEn;
  logic       abortReq;

`ifdef AES_CTRL_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  // State, round index and wait counter registers. Reset assertion takes
  // effect without a clock so no load enable can follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic. The load enable is the only output produced here
  // because the idle handshake load must happen in the accept cycle itself;
  // everything else is decoded from the registers below.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wcnt_d  = wcnt_q;
    loadEn  = 1'b0;

    unique case (state_q)
      IDLE: begin
        round_d = 4'd0;
        wcnt_d  = 4'd0;
        if (in_valid && key_ready) begin
          // Plaintext XOR round key 0 is loaded now, round 1 comes next.
          loadEn  = 1'b1;
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == LatM1L) begin
          loadEn = 1'b1;
          wcnt_d = 4'd0;
          // The final round keeps its index so the result stays tagged NR.
          if (round_q < NrL) begin
            round_d = round_q + 4'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
        wcnt_d  = 4'd0;
      end
    endcase

    // Abort overrides both the accept handshake and the output handshake.
    if (abortReq) begin
      state_d = IDLE;
      round_d = 4'd0;
      wcnt_d  = 4'd0;
      loadEn  = 1'b0;
    end
  end

  // Registered decodes; in_ready and state_en are the only paths that
  // depend combinationally on inputs.
  assign in_ready   = (state_q == IDLE) && key_ready;
  assign state_en   = loadEn;
  assign mux_sel    = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == ROUND);
  assign round_idx  = round_q;
  assign last_round = (round_q == NrL);

  // The round index may never run past the final round.
  roundIdxInRange: assert property (@(posedge clk) disable iff (!rst)
                                    round_q <= NrL);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed testbench for aes_round_ctrl. One instance uses the default
// parameters, a second one uses ROUND_LAT=3. Expected values are written
// from the accept-cycle timeline: with accept at cycle 0, loads occur at
// cycles k*ROUND_LAT for k=0..NR and out_valid rises at NR*ROUND_LAT+1.
module tb_aes_round_ctrl;

   localparam int NR = 14;

   logic clock;
   logic resetN;
   logic keyReady;
   logic inValid;
   logic outReady;
   logic abortIn;
   logic inReady, outValid, muxSel, stateEn, lastRound, busy;
   logic [3:0] roundIdx;

   logic inValid3, outReady3;
   logic inReady3, outValid3, muxSel3, stateEn3, lastRound3, busy3;
   logic [3:0] roundIdx3;

   int errors = 0;
   int checks = 0;

   aes_round_ctrl #(.NR(NR), .ROUND_LAT(1)) dut (
      .clk        (clock),
      .rst        (resetN),
      .key_ready  (keyReady),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .mux_sel    (muxSel),
      .state_en   (stateEn),
      .round_idx  (roundIdx),
      .last_round (lastRound),
      .busy       (busy)
`ifdef AES_CTRL_ABORT_EN
      ,
      .abort      (abortIn)
`endif
   );

   aes_round_ctrl #(.NR(NR), .ROUND_LAT(3)) dut3 (
      .clk        (clock),
      .rst        (resetN),
      .key_ready  (keyReady),
      .in_valid   (inValid3),
      .in_ready   (inReady3),
      .out_valid  (outValid3),
      .out_ready  (outReady3),
      .mux_sel    (muxSel3),
      .state_en   (stateEn3),
      .round_idx  (roundIdx3),
      .last_round (lastRound3),
      .busy       (busy3)
`ifdef AES_CTRL_ABORT_EN
      ,
      .abort      (1'b0)
`endif
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive the default-instance handshake inputs.
   task automatic applyStimulus(input logic iv, input logic kr, input logic orr);
      inValid  = iv;
      keyReady = kr;
      outReady = orr;
   endtask

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full block on the default instance. Entered 1 time unit after an edge in
   // IDLE with key_ready high; leaves 2 units after the edge in DONE.
   task automatic runBlock(input string tag);
      inValid = 1'b1;
      #1;
      checkOutput({tag, "_c0_in_ready"}, 32'(inReady), 32'd1);
      checkOutput({tag, "_c0_state_en"}, 32'(stateEn), 32'd1);
      checkOutput({tag, "_c0_mux_sel"}, 32'(muxSel), 32'd1);
      checkOutput({tag, "_c0_round_idx"}, 32'(roundIdx), 32'd0);
      for (int c = 1; c <= NR; c++) begin
         tick();
         inValid = 1'b0;
         #1;
         checkOutput($sformatf("%s_c%0d_state_en", tag, c), 32'(stateEn), 32'd1);
         checkOutput($sformatf("%s_c%0d_mux_sel", tag, c), 32'(muxSel), 32'd0);
         checkOutput($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'd1);
         checkOutput($sformatf("%s_c%0d_round_idx", tag, c), 32'(roundIdx), 32'(c));
         checkOutput($sformatf("%s_c%0d_last_round", tag, c), 32'(lastRound),
                     (c == NR) ? 32'd1 : 32'd0);
         checkOutput($sformatf("%s_c%0d_out_valid", tag, c), 32'(outValid), 32'd0);
      end
      tick();
      #1;
      checkOutput({tag, "_done_out_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_done_state_en"}, 32'(stateEn), 32'd0);
      checkOutput({tag, "_done_round_idx"}, 32'(roundIdx), 32'd14);
      checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done_mux_sel"}, 32'(muxSel), 32'd0);
   endtask

   // Hand the result to the consumer; leaves 2 units after an edge in IDLE.
   task automatic releaseResult(input string tag);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      #1;
      checkOutput({tag, "_rel_out_valid"}, 32'(outValid), 32'd0);
      checkOutput({tag, "_rel_round_idx"}, 32'(roundIdx), 32'd0);
      checkOutput({tag, "_rel_mux_sel"}, 32'(muxSel), 32'd1);
   endtask

   // Directed sequence.
   initial begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      abortIn   = 1'b0;
      inValid3  = 1'b0;
      outReady3 = 1'b0;
      resetN    = 1'b0;
      #12;
      checkOutput("rst_round_idx", 32'(roundIdx), 32'd0);
      checkOutput("rst_mux_sel", 32'(muxSel), 32'd1);
      checkOutput("rst_state_en", 32'(stateEn), 32'd0);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_last_round", 32'(lastRound), 32'd0);
      checkOutput("rst_in_ready_kr1", 32'(inReady), 32'd1);
      keyReady = 1'b0;
      #1;
      checkOutput("rst_in_ready_kr0", 32'(inReady), 32'd0);
      resetN = 1'b1;
      tick();

      // key_ready low holds off the accept for five cycles.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("keywait%0d_in_ready", i), 32'(inReady), 32'd0);
         checkOutput($sformatf("keywait%0d_state_en", i), 32'(stateEn), 32'd0);
         checkOutput($sformatf("keywait%0d_mux_sel", i), 32'(muxSel), 32'd1);
         tick();
      end
      keyReady = 1'b1;
      runBlock("blk1");

      // Consumer stalls for ten cycles while a new plaintext waits.
      inValid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("hold%0d_out_valid", i), 32'(outValid), 32'd1);
         checkOutput($sformatf("hold%0d_round_idx", i), 32'(roundIdx), 32'd14);
         checkOutput($sformatf("hold%0d_state_en", i), 32'(stateEn), 32'd0);
         checkOutput($sformatf("hold%0d_in_ready", i), 32'(inReady), 32'd0);
         tick();
         #1;
      end
      outReady = 1'b1;
      #1;
      checkOutput("outrdy_state_en", 32'(stateEn), 32'd0);
      checkOutput("outrdy_in_ready", 32'(inReady), 32'd0);
      tick();
      outReady = 1'b0;
      #1;
      checkOutput("reaccept_out_valid", 32'(outValid), 32'd0);
      checkOutput("reaccept_in_ready", 32'(inReady), 32'd1);
      checkOutput("reaccept_state_en", 32'(stateEn), 32'd1);
      checkOutput("reaccept_round_idx", 32'(roundIdx), 32'd0);

      // Run to round 7, then reset mid-block.
      for (int c = 1; c <= 7; c++) begin
         tick();
         inValid = 1'b0;
         #1;
         checkOutput($sformatf("prerst_c%0d_round_idx", c), 32'(roundIdx), 32'(c));
      end
      resetN = 1'b0;
      #1;
      checkOutput("midrst_state_en", 32'(stateEn), 32'd0);
      checkOutput("midrst_round_idx", 32'(roundIdx), 32'd0);
      checkOutput("midrst_mux_sel", 32'(muxSel), 32'd1);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_last_round", 32'(lastRound), 32'd0);
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      tick();
      #1;
      checkOutput("midrst_hold_state_en", 32'(stateEn), 32'd0);
      checkOutput("midrst_hold_round_idx", 32'(roundIdx), 32'd0);
      resetN = 1'b1;
      tick();
      runBlock("blk2");
      releaseResult("blk2");

      // ROUND_LAT=3 instance: loads every third cycle, done at cycle 43.
      tick();
      inValid3 = 1'b1;
      #1;
      checkOutput("lat3_c0_state_en", 32'(stateEn3), 32'd1);
      checkOutput("lat3_c0_mux_sel", 32'(muxSel3), 32'd1);
      for (int c = 1; c <= 43; c++) begin
         tick();
         inValid3 = 1'b0;
         #1;
         checkOutput($sformatf("lat3_c%0d_state_en", c), 32'(stateEn3),
                     ((c % 3 == 0) && (c <= 42)) ? 32'd1 : 32'd0);
         checkOutput($sformatf("lat3_c%0d_round_idx", c), 32'(roundIdx3),
                     (c <= 42) ? 32'((c + 2) / 3) : 32'd14);
         checkOutput($sformatf("lat3_c%0d_out_valid", c), 32'(outValid3),
                     (c == 43) ? 32'd1 : 32'd0);
         checkOutput($sformatf("lat3_c%0d_last_round", c), 32'(lastRound3),
                     (c >= 40) ? 32'd1 : 32'd0);
      end
      outReady3 = 1'b1;
      tick();
      outReady3 = 1'b0;
      #1;
      checkOutput("lat3_rel_out_valid", 32'(outValid3), 32'd0);
      checkOutput("lat3_rel_round_idx", 32'(roundIdx3), 32'd0);

`ifdef AES_CTRL_ABORT_EN
      // Abort beats the accept handshake in IDLE.
      tick();
      inValid = 1'b1;
      abortIn = 1'b1;
      #1;
      checkOutput("abidle_state_en", 32'(stateEn), 32'd0);
      tick();
      abortIn = 1'b0;
      inValid = 1'b0;
      #1;
      checkOutput("abidle_mux_sel", 32'(muxSel), 32'd1);
      checkOutput("abidle_busy", 32'(busy), 32'd0);
      // Abort during round 5.
      tick();
      inValid = 1'b1;
      #1;
      checkOutput("abrnd_c0_state_en", 32'(stateEn), 32'd1);
      for (int c = 1; c <= 5; c++) begin
         tick();
         inValid = 1'b0;
         #1;
         checkOutput($sformatf("abrnd_c%0d_round_idx", c), 32'(roundIdx), 32'(c));
      end
      abortIn = 1'b1;
      #1;
      checkOutput("abrnd_state_en", 32'(stateEn), 32'd0);
      tick();
      abortIn = 1'b0;
      #1;
      checkOutput("abrnd_round_idx", 32'(roundIdx), 32'd0);
      checkOutput("abrnd_mux_sel", 32'(muxSel), 32'd1);
      checkOutput("abrnd_busy", 32'(busy), 32'd0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
